// File: rtl/disp_pkg.sv
// Shared types and helpers for the change-dispense arbiter.
//   disp_state_t     : dispense sequencer states
//   NICKEL_CENTS     : value of one nickel, in cents
//   DIME_CENTS       : value of one dime, in cents
//   change_to_counts : release change bits -> {nick_cnt[0], dime_cnt[1:0]}
//   counts_to_cents  : coin counts -> total change in cents
package disp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DIME_ON,
      DIME_GAP,
      NICK_ON,
      NICK_GAP,
      DOOR_ON,
      DOOR_GAP
   } disp_state_t;

   localparam int NICKEL_CENTS = 5;
   localparam int DIME_CENTS   = 10;

   // d1 and d2 may both be set; the dime count then reaches 3.
   function automatic logic [2:0] change_to_counts(input logic n1, input logic d1, input logic d2);
      logic [1:0] dimes;
      dimes = {1'b0, d1} + {d2, 1'b0};
      return {n1, dimes};
   endfunction

   function automatic int counts_to_cents(input logic nick_cnt, input logic [1:0] dime_cnt);
      return int'(nick_cnt) * NICKEL_CENTS + int'(dime_cnt) * DIME_CENTS;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority index for this decision
//   gnt       : one-hot grant (all zero when no request)
//   gnt_idx   : index of the granted requester
//   gnt_valid : at least one request is present
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_valid
);

   localparam int W = $clog2(N);

   int idx;

   // Scan offsets from farthest to nearest so the nearest set bit at or
   // after ptr is the one left standing.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (req[idx]) begin
            gnt_idx   = W'(idx);
            gnt_valid = 1'b1;
         end
      end
      if (gnt_valid) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/change_dispense_arbiter.sv
// Shares one coin hopper and door driver among NUM_UNITS vending FSMs.
// Release strobes are latched per unit, granted round-robin, then played
// out as timed pulses: dimes, then the nickel, then the unit's door.
//   clk, rst      : clock, asynchronous active-high reset
//   req_r         : per-unit release strobe (one cycle)
//   req_n1/d1/d2  : per-unit change bits, qualified by req_r
//   hop_empty     : hopper low-coin sense, holds off new coin pulses
//   hop_nickel    : nickel eject pulse
//   hop_dime      : dime eject pulse
//   door_open     : one-hot door pulse to the unit being served
//   busy          : sequencer not idle
//   grant_id      : unit currently being served
//   err           : sticky per-unit protocol error flags
module change_dispense_arbiter
   import disp_pkg::*;
#(
   parameter int NUM_UNITS = 4,
   parameter int PULSE_CYC = 4,
   parameter int GAP_CYC   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_UNITS-1:0]         req_r,
   input  logic [NUM_UNITS-1:0]         req_n1,
   input  logic [NUM_UNITS-1:0]         req_d1,
   input  logic [NUM_UNITS-1:0]         req_d2,
   input  logic                         hop_empty,
   output logic                         hop_nickel,
   output logic                         hop_dime,
   output logic [NUM_UNITS-1:0]         door_open,
   output logic                         busy,
   output logic [$clog2(NUM_UNITS)-1:0] grant_id,
   output logic [NUM_UNITS-1:0]         err
);

   localparam int IW   = $clog2(NUM_UNITS);
   localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYC - 1);

   disp_state_t          state_reg, state_next, seq_target;
   logic                 seq_stall;
   logic [TW-1:0]        timer_reg, timer_next;
   logic                 nick_cnt_reg, nick_cnt_next;
   logic [1:0]           dime_cnt_reg, dime_cnt_next;
   logic [IW-1:0]        grant_id_reg, grant_id_next;
   logic [IW-1:0]        ptr_reg, ptr_next;
   logic [NUM_UNITS-1:0] pend_reg, pend_next, pend_clr;
   logic [NUM_UNITS-1:0] err_reg, err_next;
   logic [NUM_UNITS-1:0] occupied, accept;
   logic                 slot_nick_reg [NUM_UNITS];
   logic [1:0]           slot_dime_reg [NUM_UNITS];
   logic [NUM_UNITS-1:0] arb_gnt;
   logic [IW-1:0]        arb_idx;
   logic                 arb_valid;
   logic                 hop_dime_reg, hop_nickel_reg;
   logic [NUM_UNITS-1:0] door_open_reg, door_open_next;

   // A slot is occupied while pending and also while it is being served,
   // so a repeat strobe during service is flagged rather than queued.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
         assign occupied[gi] = pend_reg[gi] |
                               ((state_reg != IDLE) && (grant_id_reg == IW'(gi)));
         assign accept[gi]   = req_r[gi] & ~occupied[gi];
         assign err_next[gi] = err_reg[gi] |
                               (req_r[gi] & occupied[gi]) |
                               (~req_r[gi] & (req_n1[gi] | req_d1[gi] | req_d2[gi]));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_nick_reg[gi] <= 1'b0;
               slot_dime_reg[gi] <= '0;
            end else if (accept[gi]) begin
               {slot_nick_reg[gi], slot_dime_reg[gi]} <=
                  change_to_counts(req_n1[gi], req_d1[gi], req_d2[gi]);
            end
         end
      end
   endgenerate

   assign pend_next = (pend_reg & ~pend_clr) | accept;

   rr_arbiter #(.N(NUM_UNITS)) u_arb (
      .req       (pend_reg),
      .ptr       (ptr_reg),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   // Next step of the coin/door sequence from the remaining counts.
   always_comb begin
      if (dime_cnt_reg != 2'd0) begin
         seq_target = DIME_ON;
      end else if (nick_cnt_reg) begin
         seq_target = NICK_ON;
      end else begin
         seq_target = DOOR_ON;
      end
   end

   assign seq_stall = hop_empty && (seq_target != DOOR_ON);

   always_comb begin
      state_next    = state_reg;
      timer_next    = timer_reg;
      nick_cnt_next = nick_cnt_reg;
      dime_cnt_next = dime_cnt_reg;
      grant_id_next = grant_id_reg;
      ptr_next      = ptr_reg;
      pend_clr      = '0;
      case (state_reg)
         IDLE: begin
            if (arb_valid) begin
               state_next    = LOAD;
               timer_next    = '0;
               grant_id_next = arb_idx;
               ptr_next      = (arb_idx == IW'(NUM_UNITS - 1)) ? '0 : arb_idx + 1'b1;
               pend_clr      = arb_gnt;
               nick_cnt_next = slot_nick_reg[arb_idx];
               dime_cnt_next = slot_dime_reg[arb_idx];
            end
         end
         LOAD, DIME_GAP, NICK_GAP, DOOR_GAP: begin
            if (timer_reg != '0) begin
               timer_next = timer_reg - 1'b1;
            end else if (state_reg == DOOR_GAP) begin
               state_next = IDLE;
            end else if (!seq_stall) begin
               // while stalled the state and the zeroed timer simply hold
               state_next = seq_target;
               timer_next = PULSE_LOAD;
            end
         end
         DIME_ON: begin
            if (timer_reg != '0) begin
               timer_next = timer_reg - 1'b1;
            end else begin
               state_next    = DIME_GAP;
               timer_next    = GAP_LOAD;
               dime_cnt_next = dime_cnt_reg - 1'b1;
            end
         end
         NICK_ON: begin
            if (timer_reg != '0) begin
               timer_next = timer_reg - 1'b1;
            end else begin
               state_next    = NICK_GAP;
               timer_next    = GAP_LOAD;
               nick_cnt_next = 1'b0;
            end
         end
         DOOR_ON: begin
            if (timer_reg != '0) begin
               timer_next = timer_reg - 1'b1;
            end else begin
               state_next = DOOR_GAP;
               timer_next = GAP_LOAD;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pulse outputs are decoded from the next state so they are registered
   // and line up exactly with the ON states.
   always_comb begin
      door_open_next = '0;
      if (state_next == DOOR_ON) begin
         door_open_next[grant_id_next] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         timer_reg      <= '0;
         nick_cnt_reg   <= 1'b0;
         dime_cnt_reg   <= '0;
         grant_id_reg   <= '0;
         ptr_reg        <= '0;
         pend_reg       <= '0;
         err_reg        <= '0;
         hop_dime_reg   <= 1'b0;
         hop_nickel_reg <= 1'b0;
         door_open_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         nick_cnt_reg   <= nick_cnt_next;
         dime_cnt_reg   <= dime_cnt_next;
         grant_id_reg   <= grant_id_next;
         ptr_reg        <= ptr_next;
         pend_reg       <= pend_next;
         err_reg        <= err_next;
         hop_dime_reg   <= (state_next == DIME_ON);
         hop_nickel_reg <= (state_next == NICK_ON);
         door_open_reg  <= door_open_next;
      end
   end

   assign hop_dime   = hop_dime_reg;
   assign hop_nickel = hop_nickel_reg;
   assign door_open  = door_open_reg;
   assign busy       = (state_reg != IDLE);
   assign grant_id   = grant_id_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_change_dispense_arbiter.sv
// Directed bench for change_dispense_arbiter. Cycle 0 of each scenario is
// the cycle the first strobe is driven; outputs are recorded per cycle
// (1 time unit after the rising edge) into bit traces and compared with
// hand-derived pulse windows.
module tb_change_dispense_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_r, req_n1, req_d1, req_d2;
   logic       hop_empty;
   logic       hop_nickel, hop_dime, busy;
   logic [3:0] door_open, err;
   logic [1:0] grant_id;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [63:0] tr_dime, tr_nick, tr_busy;
   logic [63:0] tr_door [4];
   logic [63:0] tr_err  [4];
   logic [1:0]  tr_gid  [64];

   change_dispense_arbiter #(
      .NUM_UNITS (4),
      .PULSE_CYC (4),
      .GAP_CYC   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_r      (req_r),
      .req_n1     (req_n1),
      .req_d1     (req_d1),
      .req_d2     (req_d2),
      .hop_empty  (hop_empty),
      .hop_nickel (hop_nickel),
      .hop_dime   (hop_dime),
      .door_open  (door_open),
      .busy       (busy),
      .grant_id   (grant_id),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mask(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_r  = '0;
      req_n1 = '0;
      req_d1 = '0;
      req_d2 = '0;
   endtask

   task automatic strobe(input int u, input logic n1, input logic d1, input logic d2);
      req_r[u]  = 1'b1;
      req_n1[u] = n1;
      req_d1[u] = d1;
      req_d2[u] = d2;
   endtask

   task automatic clear_trace();
      tr_dime = '0;
      tr_nick = '0;
      tr_busy = '0;
      for (int u = 0; u < 4; u++) begin
         tr_door[u] = '0;
         tr_err[u]  = '0;
      end
      for (int c = 0; c < 64; c++) tr_gid[c] = '0;
   endtask

   task automatic sample(input int c);
      tr_dime[c] = hop_dime;
      tr_nick[c] = hop_nickel;
      tr_busy[c] = busy;
      tr_gid[c]  = grant_id;
      for (int u = 0; u < 4; u++) begin
         tr_door[u][c] = door_open[u];
         tr_err[u][c]  = err[u];
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      hop_empty = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      hop_empty = 1'b0;
      rst = 1'b1;
      #2;
      tests_run++;
      if ({hop_dime, hop_nickel, busy, door_open, grant_id, err} !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h want 000",
                  {hop_dime, hop_nickel, busy, door_open, grant_id, err});
      end
      tick();
      rst = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({hop_dime, hop_nickel, busy, door_open, grant_id, err} !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_idle: got %h want 000",
                  {hop_dime, hop_nickel, busy, door_open, grant_id, err});
      end
      $display("[TB] test_reset done");
   endtask

   // Unit 0: one dime plus one nickel.
   task automatic test_fifteen_cents();
      int bad;
      do_reset();
      clear_trace();
      for (int c = 0; c < 24; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) strobe(0, 1'b1, 1'b1, 1'b0);
         tick();
      end
      tests_run++;
      if (tr_dime !== mask(3, 6)) begin
         tests_failed++;
         $display("FAIL t15_dime: got %h want %h", tr_dime, mask(3, 6));
      end
      tests_run++;
      if (tr_nick !== mask(9, 12)) begin
         tests_failed++;
         $display("FAIL t15_nick: got %h want %h", tr_nick, mask(9, 12));
      end
      tests_run++;
      if (tr_door[0] !== mask(15, 18)) begin
         tests_failed++;
         $display("FAIL t15_door0: got %h want %h", tr_door[0], mask(15, 18));
      end
      tests_run++;
      if ((tr_door[1] | tr_door[2] | tr_door[3]) !== 64'h0) begin
         tests_failed++;
         $display("FAIL t15_other_doors: got %h want 0", tr_door[1] | tr_door[2] | tr_door[3]);
      end
      tests_run++;
      if (tr_busy !== mask(2, 20)) begin
         tests_failed++;
         $display("FAIL t15_busy: got %h want %h", tr_busy, mask(2, 20));
      end
      bad = 0;
      for (int c = 2; c <= 20; c++) if (tr_gid[c] !== 2'd0) bad++;
      tests_run++;
      if (bad != 0 || err !== 4'h0) begin
         tests_failed++;
         $display("FAIL t15_gid_err: bad_gid_cycles %0d err %h want 0 and 0", bad, err);
      end
      $display("[TB] test_fifteen_cents done");
   endtask

   // Unit 2: two dimes. Round-robin pointer is 1 after the previous test.
   task automatic test_two_dimes();
      int bad;
      clear_trace();
      for (int c = 0; c < 24; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) strobe(2, 1'b0, 1'b0, 1'b1);
         tick();
      end
      tests_run++;
      if (tr_dime !== (mask(3, 6) | mask(9, 12))) begin
         tests_failed++;
         $display("FAIL d2_dime: got %h want %h", tr_dime, mask(3, 6) | mask(9, 12));
      end
      tests_run++;
      if (tr_nick !== 64'h0) begin
         tests_failed++;
         $display("FAIL d2_nick: got %h want 0", tr_nick);
      end
      tests_run++;
      if (tr_door[2] !== mask(15, 18)) begin
         tests_failed++;
         $display("FAIL d2_door2: got %h want %h", tr_door[2], mask(15, 18));
      end
      bad = 0;
      for (int c = 2; c <= 20; c++) if (tr_gid[c] !== 2'd2) bad++;
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL d2_grant_id: cycles not 2 = %0d want 0", bad);
      end
      $display("[TB] test_two_dimes done");
   endtask

   // Units 1 and 3 together from ptr 0, then units 0 and 1 to show the
   // pointer wrapped back to 0.
   task automatic test_round_robin();
      do_reset();
      clear_trace();
      for (int c = 0; c < 20; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) begin
            strobe(1, 1'b0, 1'b0, 1'b0);
            strobe(3, 1'b0, 1'b0, 1'b0);
         end
         tick();
      end
      tests_run++;
      if (tr_door[1] !== mask(3, 6)) begin
         tests_failed++;
         $display("FAIL rr_door1: got %h want %h", tr_door[1], mask(3, 6));
      end
      tests_run++;
      if (tr_door[3] !== mask(11, 14)) begin
         tests_failed++;
         $display("FAIL rr_door3: got %h want %h", tr_door[3], mask(11, 14));
      end
      tests_run++;
      if (tr_busy !== (mask(2, 8) | mask(10, 16))) begin
         tests_failed++;
         $display("FAIL rr_busy: got %h want %h", tr_busy, mask(2, 8) | mask(10, 16));
      end
      clear_trace();
      for (int c = 0; c < 20; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) begin
            strobe(0, 1'b0, 1'b0, 1'b0);
            strobe(1, 1'b0, 1'b0, 1'b0);
         end
         tick();
      end
      tests_run++;
      if (tr_door[0] !== mask(3, 6)) begin
         tests_failed++;
         $display("FAIL rr_wrap_door0: got %h want %h", tr_door[0], mask(3, 6));
      end
      tests_run++;
      if (tr_door[1] !== mask(11, 14)) begin
         tests_failed++;
         $display("FAIL rr_wrap_door1: got %h want %h", tr_door[1], mask(11, 14));
      end
      $display("[TB] test_round_robin done");
   endtask

   // Repeat strobe while served, and a change bit without a strobe.
   task automatic test_errors();
      do_reset();
      clear_trace();
      for (int c = 0; c < 16; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0 || c == 4) strobe(0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      tests_run++;
      if (tr_door[0] !== mask(3, 6)) begin
         tests_failed++;
         $display("FAIL err_single_door0: got %h want %h", tr_door[0], mask(3, 6));
      end
      tests_run++;
      if (tr_busy !== mask(2, 8)) begin
         tests_failed++;
         $display("FAIL err_busy: got %h want %h", tr_busy, mask(2, 8));
      end
      tests_run++;
      if (tr_err[0] !== mask(5, 15)) begin
         tests_failed++;
         $display("FAIL err0_trace: got %h want %h", tr_err[0], mask(5, 15));
      end
      clear_trace();
      for (int c = 0; c < 6; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) req_d1[3] = 1'b1;
         tick();
      end
      tests_run++;
      if (tr_err[3] !== mask(1, 5)) begin
         tests_failed++;
         $display("FAIL err3_trace: got %h want %h", tr_err[3], mask(1, 5));
      end
      tests_run++;
      if (tr_err[0] !== mask(0, 5)) begin
         tests_failed++;
         $display("FAIL err0_sticky: got %h want %h", tr_err[0], mask(0, 5));
      end
      tests_run++;
      if (tr_busy !== 64'h0 || (tr_err[1] | tr_err[2]) !== 64'h0) begin
         tests_failed++;
         $display("FAIL err3_side: busy %h err12 %h want 0 and 0", tr_busy, tr_err[1] | tr_err[2]);
      end
      $display("[TB] test_errors done");
   endtask

   // Hopper empty at request time; released at cycle 20.
   task automatic test_hopper_stall();
      do_reset();
      clear_trace();
      hop_empty = 1'b1;
      for (int c = 0; c < 36; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) strobe(1, 1'b0, 1'b1, 1'b0);
         if (c == 20) hop_empty = 1'b0;
         tick();
      end
      tests_run++;
      if (tr_dime !== mask(21, 24)) begin
         tests_failed++;
         $display("FAIL stall_dime: got %h want %h", tr_dime, mask(21, 24));
      end
      tests_run++;
      if (tr_door[1] !== mask(27, 30)) begin
         tests_failed++;
         $display("FAIL stall_door1: got %h want %h", tr_door[1], mask(27, 30));
      end
      tests_run++;
      if (tr_busy !== mask(2, 32)) begin
         tests_failed++;
         $display("FAIL stall_busy: got %h want %h", tr_busy, mask(2, 32));
      end
      tests_run++;
      if (tr_nick !== 64'h0) begin
         tests_failed++;
         $display("FAIL stall_nick: got %h want 0", tr_nick);
      end
      $display("[TB] test_hopper_stall done");
   endtask

   // Capture while busy; hop_empty rising mid-pulse neither cuts the dime
   // pulse nor delays the door pulse.
   task automatic test_back_to_back();
      do_reset();
      clear_trace();
      for (int c = 0; c < 26; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) strobe(0, 1'b0, 1'b0, 1'b0);
         if (c == 5) strobe(2, 1'b0, 1'b1, 1'b0);
         hop_empty = (c >= 12 && c <= 20);
         tick();
      end
      hop_empty = 1'b0;
      tests_run++;
      if (tr_dime !== mask(11, 14)) begin
         tests_failed++;
         $display("FAIL b2b_dime: got %h want %h", tr_dime, mask(11, 14));
      end
      tests_run++;
      if (tr_door[2] !== mask(17, 20) || tr_door[0] !== mask(3, 6)) begin
         tests_failed++;
         $display("FAIL b2b_doors: door0 %h door2 %h want %h %h",
                  tr_door[0], tr_door[2], mask(3, 6), mask(17, 20));
      end
      tests_run++;
      if (tr_busy !== (mask(2, 8) | mask(10, 22))) begin
         tests_failed++;
         $display("FAIL b2b_busy: got %h want %h", tr_busy, mask(2, 8) | mask(10, 22));
      end
      tests_run++;
      if (tr_gid[12] !== 2'd2) begin
         tests_failed++;
         $display("FAIL b2b_grant_id: got %0d want 2", tr_gid[12]);
      end
      $display("[TB] test_back_to_back done");
   endtask

   // Reset during the second dime pulse of unit 0 with unit 1 pending and
   // err[3] set.
   task automatic test_reset_midpulse();
      do_reset();
      clear_trace();
      for (int c = 0; c < 20; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) strobe(0, 1'b0, 1'b0, 1'b1);
         if (c == 1) begin
            strobe(1, 1'b0, 1'b0, 1'b0);
            req_n1[3] = 1'b1;
         end
         if (c == 10) begin
            rst = 1'b1;
            #1;
            tests_run++;
            if ({hop_dime, hop_nickel, busy, door_open, err} !== 11'h000) begin
               tests_failed++;
               $display("FAIL rstmid_outputs: got %h want 000",
                        {hop_dime, hop_nickel, busy, door_open, err});
            end
         end
         if (c == 11) rst = 1'b0;
         tick();
      end
      tests_run++;
      if (tr_dime !== (mask(3, 6) | mask(9, 10))) begin
         tests_failed++;
         $display("FAIL rstmid_dime: got %h want %h", tr_dime, mask(3, 6) | mask(9, 10));
      end
      tests_run++;
      if (tr_err[3] !== mask(2, 10)) begin
         tests_failed++;
         $display("FAIL rstmid_err3: got %h want %h", tr_err[3], mask(2, 10));
      end
      tests_run++;
      if (tr_door[1] !== 64'h0 || tr_busy !== mask(2, 10)) begin
         tests_failed++;
         $display("FAIL rstmid_pend_lost: door1 %h busy %h want 0 %h",
                  tr_door[1], tr_busy, mask(2, 10));
      end
      clear_trace();
      for (int c = 0; c < 12; c++) begin
         sample(c);
         idle_inputs();
         if (c == 0) strobe(0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      tests_run++;
      if (tr_door[0] !== mask(3, 6)) begin
         tests_failed++;
         $display("FAIL rstmid_new_door0: got %h want %h", tr_door[0], mask(3, 6));
      end
      tests_run++;
      if ((tr_dime | tr_nick) !== 64'h0 || tr_err[0] !== 64'h0) begin
         tests_failed++;
         $display("FAIL rstmid_new_clean: coins %h err0 %h want 0 0", tr_dime | tr_nick, tr_err[0]);
      end
      $display("[TB] test_reset_midpulse done");
   endtask

   initial begin
      test_reset();
      test_fifteen_cents();
      test_two_dimes();
      test_round_robin();
      test_errors();
      test_hopper_stall();
      test_back_to_back();
      test_reset_midpulse();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
